uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares the single buart transmitter (wr/busy/tx_data) between NREQ byte producers, e.g. the CPU SEND path and a debug dump engine.
- Sequences each byte as wait-not-busy, one-cycle wr strobe, then a settle gap, so requesters never drive the UART directly.
- Round-robin fairness between requesters.
- Optional packet lock keeps multi-byte messages contiguous on TXD.
- Sits between the requesters and the _uart0 instance in top.

Parameters:
NREQ, 4, number of requesters (2..8)
GAP, 1, cycles after the wr strobe before busy is sampled again (covers buart busy-rise latency)
LOCK_TIMEOUT, 1023, idle cycles after which a locked owner with valid low loses the lock (0 = lock never times out)

Ports:
clk  in  1  system clock; all logic on its rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  NREQ  requester i has a byte pending
req_data  in  8*NREQ  byte of requester i, bits [8i+7:8i]
req_last  in  NREQ  byte of requester i ends its packet; 1 = unlocked single byte
req_ready  out  NREQ  one-cycle accept pulse to requester i
uart_wr  out  1  write strobe to buart
uart_data  out  8  byte to buart tx_data
uart_busy  in  1  buart transmitter busy
grant_id  out  clog2(NREQ)  requester of the last accepted byte
locked  out  1  packet lock held by grant_id

Behaviour:
- Reset values: uart_wr=0, uart_data=8'h00, req_ready=0, grant_id=NREQ-1 (so req 0 has first priority), locked=0, state=IDLE, gap and timeout counters=0.
- State IDLE:
  - If uart_busy=0 and a candidate has valid=1, latch the winner's data, id and last flag, then go to STROBE.
  - Unlocked: candidate = first valid requester scanning from (grant_id+1) mod NREQ, with wrap-around.
  - Locked: the only candidate is grant_id.
- State STROBE (exactly 1 cycle): uart_wr=1, uart_data=latched byte, req_ready[winner]=1.
  - locked <= ~last; grant_id <= winner.
  - Go to SETTLE; load gap counter with GAP.
- State SETTLE: uart_wr=0. Count down GAP cycles ignoring uart_busy, then go to IDLE.
- Latency: valid seen in IDLE at cycle T (busy low) -> wr and ready at T+1 -> earliest next grant at T+2+GAP.
- uart_data holds its last value outside STROBE.
- req_ready pulses in the same cycle as uart_wr, never otherwise. Requester treats a ready pulse as consumption.
- Requester contract: hold valid, data and last stable until ready. Dropping valid before grant withdraws the request, no error.
- Lock timeout: when locked, in IDLE, with the owner's valid low, count cycles. At LOCK_TIMEOUT, clear locked and rearbitrate that same cycle. The counter clears whenever the owner's valid is high.
- Simultaneous events:
  - busy falling and valid rising in the same cycle: grant in that cycle.
  - Several valids: round-robin as above.
  - Owner re-asserting valid on the timeout cycle: owner wins, lock kept.
- Reset mid-operation:
  - Reset in STROBE: wr and ready are still high that cycle (registered), both low the next; the byte counts as sent.
  - Reset during SETTLE or with a lock held: return to reset values; the lock is lost.
- Width: counters are sized clog2(GAP+1) and clog2(LOCK_TIMEOUT+1). No other arithmetic.

Decomposition:
- Package uart_arb_pkg: state encoding (IDLE=2'd0, STROBE=2'd1, SETTLE=2'd2) and a clog2 function.
- Sub-module uart_rr_pick: combinational round-robin priority picker. Inputs are the valid vector and the last grant; outputs are found plus index. Instantiated once.

Test Plan:
- Single requester: req1 valid with data 8'h61, busy=0 -> wr high exactly one cycle with uart_data=8'h61 and req_ready[1] in the same cycle; no further wr while busy=1.
- Fairness: all 4 valid continuously with last=1, grant_id starting at 3 -> grant order 0,1,2,3,0. Each wr only after busy has dropped, wr pulses spaced at least 2+GAP cycles.
- Packet lock: req2 sends 3 bytes (last=0,0,1) while req0 is also valid -> TXD order 2,2,2,0. locked=1 between req2's bytes, 0 after its third byte.
- Lock timeout with LOCK_TIMEOUT=8: req3 sends last=0 then drops valid, req1 valid -> req1 granted exactly 8 IDLE cycles later; locked falls in that same cycle.
- Busy/valid race: busy falls in the same cycle req0 becomes valid -> wr on the next cycle. valid withdrawn while busy=1 -> no wr and no ready.
- Reset during STROBE: wr and ready high that cycle; after reset all outputs are at reset values, and the next grant goes to req0.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared constants and width helpers for the UART transmit arbiter.
// State encodings are plain 2-bit constants so legacy code can compare against them.
package uart_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STROBE = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Register width able to hold 0..value-1, never narrower than one bit.
  function automatic int cwidth(input int value);
    int w;
    w = clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first valid requester after last_grant_i,
// wrapping around so last_grant_i itself has the lowest priority.
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]                      valid_i,
  input  logic [uart_arb_pkg::clog2(NREQ)-1:0] last_grant_i,
  output logic                                 found_o,
  output logic [uart_arb_pkg::clog2(NREQ)-1:0] idx_o
);

  localparam int IW = clog2(NREQ);

  int pos;

  // Scan from the farthest offset down so the nearest valid one wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = last_grant_i;
    pos     = 0;
    for (int k = NREQ; k >= 1; k--) begin
      pos = int'(last_grant_i) + k;
      if (pos >= NREQ) begin
        pos = pos - NREQ;
      end
      if (valid_i[IW'(pos)]) begin
        found_o = 1'b1;
        idx_o   = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one buart transmitter between NREQ byte producers with round-robin
// fairness, an optional packet lock, and a fixed settle gap after every write.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int GAP          = 1,
  parameter int LOCK_TIMEOUT = 1023
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NREQ-1:0]                      req_valid,
  input  logic [8*NREQ-1:0]                    req_data,
  input  logic [NREQ-1:0]                      req_last,
  output logic [NREQ-1:0]                      req_ready,
  output logic                                 uart_wr,
  output logic [7:0]                           uart_data,
  input  logic                                 uart_busy,
  output logic [uart_arb_pkg::clog2(NREQ)-1:0] grant_id,
  output logic                                 locked
);

  localparam int IW = clog2(NREQ);
  localparam int GW = cwidth(GAP + 1);
  localparam int TW = cwidth(LOCK_TIMEOUT + 1);

  logic [1:0]    state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          locked_q, locked_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] win_q, win_d;
  logic          last_q, last_d;
  logic [7:0]    data_q, data_d;

  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic          owner_valid;
  logic          timeout_hit;
  logic          arb_locked;
  logic          cand_found;
  logic [IW-1:0] cand_id;

  uart_rr_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .valid_i      (req_valid),
    .last_grant_i (grant_q),
    .found_o      (pick_found),
    .idx_o        (pick_idx)
  );

  assign owner_valid = req_valid[grant_q];
  assign timeout_hit = (LOCK_TIMEOUT != 0) && locked_q && !owner_valid &&
                       (to_cnt_q == TW'(LOCK_TIMEOUT));
  // A lapsing lock is dropped and the round-robin picker decides in the same cycle.
  assign arb_locked  = locked_q && !timeout_hit;
  assign cand_found  = arb_locked ? owner_valid : pick_found;
  assign cand_id     = arb_locked ? grant_q : pick_idx;

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    to_cnt_d = to_cnt_q;
    locked_d = locked_q;
    grant_d  = grant_q;
    win_d    = win_q;
    last_d   = last_q;
    data_d   = data_q;
    case (state_q)
      ST_IDLE: begin
        if (locked_q && !owner_valid) begin
          if (timeout_hit) begin
            locked_d = 1'b0;
            to_cnt_d = '0;
          end else if (LOCK_TIMEOUT != 0) begin
            to_cnt_d = to_cnt_q + TW'(1);
          end
        end else begin
          to_cnt_d = '0;
        end
        if (!uart_busy && cand_found) begin
          data_d  = req_data[{cand_id, 3'b000} +: 8];
          win_d   = cand_id;
          last_d  = req_last[cand_id];
          state_d = ST_STROBE;
        end
      end
      ST_STROBE: begin
        locked_d = ~last_q;
        grant_d  = win_q;
        to_cnt_d = '0;
        if (GAP == 0) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SETTLE;
          gap_d   = GW'(GAP);
        end
      end
      ST_SETTLE: begin
        // buart raises busy a cycle or so late, so it is not trusted here.
        if (gap_q <= GW'(1)) begin
          gap_d   = '0;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      gap_q    <= '0;
      to_cnt_q <= '0;
      locked_q <= 1'b0;
      grant_q  <= IW'(NREQ - 1);
      win_q    <= '0;
      last_q   <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      to_cnt_q <= to_cnt_d;
      locked_q <= locked_d;
      grant_q  <= grant_d;
      win_q    <= win_d;
      last_q   <= last_d;
      data_q   <= data_d;
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
    assign req_ready[gi] = (state_q == ST_STROBE) && (win_q == IW'(gi));
  end

  assign uart_wr   = (state_q == ST_STROBE);
  assign uart_data = data_q;
  assign grant_id  = grant_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: expected bytes are queued as requesters are loaded and
// checked as the arbiter strobes them into a simple busy-generating UART model.
module tb_uart_tx_arbiter;

  localparam int NREQ     = 4;
  localparam int GAP      = 1;
  localparam int LTO      = 8;
  localparam int BUSY_LEN = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   req_last = '0;
  logic [NREQ-1:0]   req_ready;
  logic              uart_wr;
  logic [7:0]        uart_data;
  logic              uart_busy;
  logic [1:0]        grant_id;
  logic              locked;

  uart_tx_arbiter #(
    .NREQ(NREQ), .GAP(GAP), .LOCK_TIMEOUT(LTO)
  ) dut (
    .clk       (clk),
    .reset     (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .uart_wr   (uart_wr),
    .uart_data (uart_data),
    .uart_busy (uart_busy),
    .grant_id  (grant_id),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
    logic       lock_after;
    logic [1:0] grant_after;
    logic [7:0] data_after;
  } sb_t;

  sb_t  sb[$];
  sb_t  pend;
  logic pend_valid = 1'b0;

  logic [8:0] rbuf [NREQ][16];
  int         rhead [NREQ];
  int         rtail [NREQ];
  logic [NREQ-1:0] ready_seen = '0;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   wr_count = 0;
  int   last_wr_cyc = 0;
  logic have_wr = 1'b0;
  logic locked_at_wr = 1'b0;
  logic prev_locked_at_wr = 1'b0;
  logic prev_locked = 1'b0;
  logic prev_busy = 1'b0;
  logic busy_force = 1'b0;
  int   busy_cnt = 0;

  assign uart_busy = busy_force || (busy_cnt > 0);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic load(input int id, input logic [7:0] d, input logic last);
    rbuf[id][rtail[id]] = {last, d};
    rtail[id]++;
  endtask

  task automatic expect_byte(input int id, input logic [7:0] d, input logic lock_after);
    sb_t e;
    e.id          = 2'(id);
    e.data        = d;
    e.lock_after  = lock_after;
    e.grant_after = 2'(id);
    e.data_after  = d;
    sb.push_back(e);
  endtask

  function automatic logic all_drained();
    logic ok;
    ok = (sb.size() == 0) && !pend_valid;
    for (int i = 0; i < NREQ; i++) begin
      if (rhead[i] != rtail[i]) ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (all_drained()) break;
    end
    chk("drained", {31'b0, all_drained()}, 1);
    repeat (6) @(posedge clk);
  endtask

  task automatic wait_wr(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (wr_count >= target) break;
    end
    chk("wr_wait", {31'b0, (wr_count >= target)}, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    busy_force = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      rhead[i] = 0;
      rtail[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Requester models: hold the head byte until its ready pulse has been seen.
  initial begin
    for (int i = 0; i < NREQ; i++) begin
      rhead[i] = 0;
      rtail[i] = 0;
    end
    forever begin
      @(posedge clk); #2;
      for (int i = 0; i < NREQ; i++) begin
        if (ready_seen[i] && rhead[i] < rtail[i]) rhead[i]++;
      end
      ready_seen = '0;
      for (int i = 0; i < NREQ; i++) begin
        if (rhead[i] < rtail[i]) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = rbuf[i][rhead[i]][7:0];
          req_last[i]        = rbuf[i][rhead[i]][8];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // Output monitor and UART busy model.
  initial begin
    sb_t      e;
    logic [3:0] oh;
    forever begin
      @(negedge clk);
      if (pend_valid) begin
        chk("locked_after", {31'b0, locked}, {31'b0, pend.lock_after});
        chk("grant_after", {30'b0, grant_id}, {30'b0, pend.grant_after});
        chk("data_hold", {24'b0, uart_data}, {24'b0, pend.data_after});
        pend_valid = 1'b0;
      end
      if (!uart_wr) begin
        chk("ready_without_wr", {28'b0, req_ready}, 0);
      end else begin
        wr_count++;
        if (sb.size() == 0) begin
          chk("unexpected_wr", {24'b0, uart_data}, 32'hFFFF_FFFF);
        end else begin
          e  = sb.pop_front();
          oh = 4'b0001 << e.id;
          chk("wr_data", {24'b0, uart_data}, {24'b0, e.data});
          chk("wr_ready", {28'b0, req_ready}, {28'b0, oh});
          pend       = e;
          pend_valid = 1'b1;
        end
        chk("busy_low_at_grant", {31'b0, prev_busy}, 0);
        if (have_wr) chk("wr_spacing", {31'b0, ((cyc - last_wr_cyc) >= 2 + GAP)}, 1);
        last_wr_cyc       = cyc;
        have_wr           = 1'b1;
        locked_at_wr      = locked;
        prev_locked_at_wr = prev_locked;
        $display("wr cycle=%0d data=0x%02h ready=%b locked=%b", cyc, uart_data, req_ready, locked);
      end
      ready_seen = ready_seen | req_ready;
      if (uart_wr) busy_cnt = BUSY_LEN;
      else if (busy_cnt > 0) busy_cnt--;
      prev_busy   = busy_force || (busy_cnt > 0);
      prev_locked = locked;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int n;
    sb_t e;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_wr", {31'b0, uart_wr}, 0);
    chk("rst_data", {24'b0, uart_data}, 0);
    chk("rst_ready", {28'b0, req_ready}, 0);
    chk("rst_grant", {30'b0, grant_id}, 3);
    chk("rst_locked", {31'b0, locked}, 0);

    // Single requester
    n = wr_count;
    load(1, 8'h61, 1'b1);
    expect_byte(1, 8'h61, 1'b0);
    wait_drain(100);
    chk("single_wr_count", wr_count, n + 1);

    // Fairness, all four contending
    do_reset();
    load(0, 8'hA0, 1'b1); load(0, 8'hA4, 1'b1);
    load(1, 8'hA1, 1'b1); load(2, 8'hA2, 1'b1); load(3, 8'hA3, 1'b1);
    expect_byte(0, 8'hA0, 1'b0); expect_byte(1, 8'hA1, 1'b0);
    expect_byte(2, 8'hA2, 1'b0); expect_byte(3, 8'hA3, 1'b0);
    expect_byte(0, 8'hA4, 1'b0);
    wait_drain(300);

    // Packet lock: req2 three-byte packet against req0
    do_reset();
    n = wr_count;
    load(1, 8'hB1, 1'b1);
    expect_byte(1, 8'hB1, 1'b0);
    wait_wr(n + 1, 100);
    load(0, 8'hC0, 1'b1);
    load(2, 8'hC2, 1'b0); load(2, 8'hC3, 1'b0); load(2, 8'hC4, 1'b1);
    expect_byte(2, 8'hC2, 1'b1); expect_byte(2, 8'hC3, 1'b1);
    expect_byte(2, 8'hC4, 1'b0); expect_byte(0, 8'hC0, 1'b0);
    wait_drain(300);

    // Lock timeout: owner goes quiet after an unfinished packet
    do_reset();
    n = wr_count;
    load(3, 8'hD3, 1'b0);
    expect_byte(3, 8'hD3, 1'b1);
    wait_wr(n + 1, 100);
    t = last_wr_cyc;
    load(1, 8'hD1, 1'b1);
    expect_byte(1, 8'hD1, 1'b0);
    wait_wr(n + 2, 100);
    chk("timeout_latency", last_wr_cyc - t, 2 + GAP + LTO);
    chk("timeout_locked_at_wr", {31'b0, locked_at_wr}, 0);
    chk("timeout_locked_before", {31'b0, prev_locked_at_wr}, 1);
    wait_drain(100);

    // Busy falls in the same cycle valid rises
    do_reset();
    @(posedge clk); #1 busy_force = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    busy_force = 1'b0;
    t = cyc;
    n = wr_count;
    load(0, 8'hE0, 1'b1);
    expect_byte(0, 8'hE0, 1'b0);
    wait_wr(n + 1, 50);
    chk("race_latency", last_wr_cyc, t + 1);
    wait_drain(100);

    // Request withdrawn while busy
    @(posedge clk); #1 busy_force = 1'b1;
    n = wr_count;
    load(2, 8'hE2, 1'b1);
    repeat (4) @(posedge clk);
    #1 rhead[2] = rtail[2];
    @(posedge clk);
    #1 busy_force = 1'b0;
    repeat (8) @(posedge clk);
    chk("withdraw_no_wr", wr_count, n);

    // Reset arriving during STROBE
    do_reset();
    load(1, 8'hF1, 1'b1);
    e.id = 2'd1; e.data = 8'hF1; e.lock_after = 1'b0;
    e.grant_after = 2'd3; e.data_after = 8'h00;
    sb.push_back(e);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (uart_wr) break;
    end
    chk("strobe_seen", {31'b0, uart_wr}, 1);
    chk("strobe_ready", {28'b0, req_ready}, 32'h2);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("rst2_wr", {31'b0, uart_wr}, 0);
    chk("rst2_ready", {28'b0, req_ready}, 0);
    chk("rst2_data", {24'b0, uart_data}, 0);
    chk("rst2_grant", {30'b0, grant_id}, 3);
    chk("rst2_locked", {31'b0, locked}, 0);
    rst = 1'b0;
    load(3, 8'hF3, 1'b1);
    load(0, 8'hF0, 1'b1);
    expect_byte(0, 8'hF0, 1'b0);
    expect_byte(3, 8'hF3, 1'b0);
    wait_drain(200);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
